// File: rtl/screen_pkg.sv
// Shared screen encoding and colour defaults for the game screen sequencer.
package screen_pkg;
  typedef enum logic [1:0] {
    SCR_WELCOME = 2'd0,
    SCR_PLAY    = 2'd1,
    SCR_PAUSE   = 2'd2,
    SCR_END     = 2'd3
  } screen_t;

  localparam logic [7:0] DEF_BLANK_COLOR = 8'h00;
  localparam logic [7:0] DEF_TRANSPARENT = 8'hFF;

  // Counter width able to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction
endpackage

// File: rtl/key_edge_detector.sv
// Rising-edge detector per key; history resets high so a key held through reset never fires.
module key_edge_detector #(
  parameter int N_KEYS = 2
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic [N_KEYS-1:0] keys,
  output logic [N_KEYS-1:0] press
);
  logic [N_KEYS-1:0] prev;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    always_ff @(posedge clk) begin
      if (!resetN) prev[k] <= 1'b1;
      else         prev[k] <= keys[k];
    end
    assign press[k] = keys[k] & ~prev[k];
  end
endmodule

// File: rtl/screen_sequencer.sv
// Game screen FSM with blanked transitions, END timeout, pause overlay and final RGB mux.
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int               RGB_W              = 8,
  parameter int               LIFE_W             = 4,
  parameter int               BLANK_FRAMES       = 2,
  parameter logic [RGB_W-1:0] BLANK_COLOR        = RGB_W'(DEF_BLANK_COLOR),
  parameter logic [RGB_W-1:0] TRANSPARENT        = RGB_W'(DEF_TRANSPARENT),
  parameter int               END_TIMEOUT_FRAMES = 600
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              startOfFrame,
  input  logic              keyStart,
  input  logic              keyPause,
  input  logic [LIFE_W-1:0] life,
  input  logic [RGB_W-1:0]  rgbWelcome,
  input  logic [RGB_W-1:0]  rgbMain,
  input  logic [RGB_W-1:0]  rgbPause,
  input  logic [RGB_W-1:0]  rgbEnd,
  output logic [RGB_W-1:0]  RGB,
  output logic [1:0]        screen,
  output logic              gameRun,
  output logic              newGame,
  output logic              paused
);
  localparam int BW = cnt_w(BLANK_FRAMES);
  localparam int EW = cnt_w(END_TIMEOUT_FRAMES);
  localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_FRAMES);
  localparam logic [EW-1:0] END_MAX    = EW'(END_TIMEOUT_FRAMES);
  localparam logic [EW-1:0] END_LAST   = EW'((END_TIMEOUT_FRAMES > 0) ? END_TIMEOUT_FRAMES - 1 : 0);
  localparam bit            END_TO_EN  = (END_TIMEOUT_FRAMES > 0);

  screen_t          state, nstate;
  logic [BW-1:0]    blank_cnt;
  logic [EW-1:0]    end_cnt;
  logic [1:0]       press;
  logic             start_press, pause_press, blank_act, timeout_hit;
  logic [RGB_W-1:0] pix_nxt;

  key_edge_detector #(.N_KEYS(2)) u_keys (
    .clk    (clk),
    .resetN (resetN),
    .keys   ({keyPause, keyStart}),
    .press  (press)
  );

  assign start_press = press[0];
  assign pause_press = press[1];
  assign blank_act   = (blank_cnt != '0);
  // Fires on the frame strobe that carries end_cnt up to the timeout value.
  assign timeout_hit = END_TO_EN && startOfFrame && (end_cnt >= END_LAST);

  always_comb begin
    nstate = state;
    if (!blank_act) begin
      case (state)
        SCR_WELCOME: if (start_press) nstate = SCR_PLAY;
        SCR_PLAY: begin
          if (life == '0)       nstate = SCR_END;
          else if (pause_press) nstate = SCR_PAUSE;
        end
        SCR_PAUSE: begin
          if (life == '0)       nstate = SCR_END;
          else if (start_press) nstate = SCR_WELCOME;
          else if (pause_press) nstate = SCR_PLAY;
        end
        SCR_END: if (start_press || timeout_hit) nstate = SCR_WELCOME;
        default: nstate = SCR_WELCOME;
      endcase
    end
  end

  always_comb begin
    pix_nxt = BLANK_COLOR;
    if (!blank_act) begin
      case (state)
        SCR_WELCOME: pix_nxt = rgbWelcome;
        SCR_PLAY:    pix_nxt = rgbMain;
        SCR_PAUSE:   pix_nxt = (rgbPause != TRANSPARENT) ? rgbPause : rgbMain;
        SCR_END:     pix_nxt = rgbEnd;
        default:     pix_nxt = BLANK_COLOR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state     <= SCR_WELCOME;
      blank_cnt <= '0;
      end_cnt   <= '0;
      RGB       <= '0;
      newGame   <= 1'b0;
    end else begin
      state   <= nstate;
      RGB     <= pix_nxt;
      newGame <= (state == SCR_WELCOME) && (nstate == SCR_PLAY);
      if (nstate != state)              blank_cnt <= BLANK_LOAD;
      else if (startOfFrame && blank_act) blank_cnt <= blank_cnt - 1'b1;
      // Held at zero outside END, so it always starts fresh on entry.
      if (state != SCR_END)                         end_cnt <= '0;
      else if (startOfFrame && (end_cnt < END_MAX)) end_cnt <= end_cnt + 1'b1;
    end
  end

  assign screen  = state;
  assign gameRun = (state == SCR_PLAY) && !blank_act;
  assign paused  = (state == SCR_PAUSE);
endmodule

// File: tb/tb_screen_sequencer.sv
// Scoreboard bench: stimulus queues hand-computed expectations, a negedge monitor compares them.
module tb_screen_sequencer;
  import screen_pkg::*;

  logic       clk = 1'b0;
  logic       resetN, resetN0, startOfFrame, keyStart, keyStart0, keyPause;
  logic [3:0] life, life0;
  logic [7:0] rgbWelcome, rgbMain, rgbPause, rgbEnd;
  logic [7:0] RGB, RGB0;
  logic [1:0] screen, screen0;
  logic       gameRun, gameRun0, newGame, newGame0, paused, paused0;

  always #5 clk = ~clk;

  screen_sequencer #(.BLANK_FRAMES(2), .END_TIMEOUT_FRAMES(4)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .keyStart(keyStart),
    .keyPause(keyPause), .life(life), .rgbWelcome(rgbWelcome), .rgbMain(rgbMain),
    .rgbPause(rgbPause), .rgbEnd(rgbEnd), .RGB(RGB), .screen(screen),
    .gameRun(gameRun), .newGame(newGame), .paused(paused)
  );

  screen_sequencer #(.BLANK_FRAMES(2), .END_TIMEOUT_FRAMES(0)) dut0 (
    .clk(clk), .resetN(resetN0), .startOfFrame(startOfFrame), .keyStart(keyStart0),
    .keyPause(keyPause), .life(life0), .rgbWelcome(rgbWelcome), .rgbMain(rgbMain),
    .rgbPause(rgbPause), .rgbEnd(rgbEnd), .RGB(RGB0), .screen(screen0),
    .gameRun(gameRun0), .newGame(newGame0), .paused(paused0)
  );

  typedef struct {
    string      name;
    bit         sel;
    logic [1:0] scr;
    logic [7:0] rgb;
    logic       gr, ps, ng;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [1:0] g_scr;
      logic [7:0] g_rgb;
      logic       g_gr, g_ps, g_ng;
      e = q.pop_front();
      if (e.sel) begin
        g_scr = screen0; g_rgb = RGB0; g_gr = gameRun0; g_ps = paused0; g_ng = newGame0;
      end else begin
        g_scr = screen;  g_rgb = RGB;  g_gr = gameRun;  g_ps = paused;  g_ng = newGame;
      end
      n_tests++;
      if ({g_scr, g_rgb, g_gr, g_ps, g_ng} !== {e.scr, e.rgb, e.gr, e.ps, e.ng}) begin
        n_fail++;
        $display("FAIL %s: got scr=%0d rgb=%h gameRun=%b paused=%b newGame=%b, want scr=%0d rgb=%h gameRun=%b paused=%b newGame=%b",
                 e.name, g_scr, g_rgb, g_gr, g_ps, g_ng, e.scr, e.rgb, e.gr, e.ps, e.ng);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input string n, input bit s, input logic [1:0] scr, input logic [7:0] rgb,
                    input logic gr, input logic ps, input logic ng);
    exp_t e;
    e.name = n; e.sel = s; e.scr = scr; e.rgb = rgb; e.gr = gr; e.ps = ps; e.ng = ng;
    q.push_back(e);
  endtask

  // One clock, then expectation for the main DUT.
  task automatic t(input string n, input logic [1:0] scr, input logic [7:0] rgb,
                   input logic gr, input logic ps, input logic ng);
    tick();
    ex(n, 1'b0, scr, rgb, gr, ps, ng);
  endtask

  // One clock carrying a frame strobe, then expectation for the main DUT.
  task automatic f(input string n, input logic [1:0] scr, input logic [7:0] rgb,
                   input logic gr, input logic ps, input logic ng);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    ex(n, 1'b0, scr, rgb, gr, ps, ng);
  endtask

  localparam logic [1:0] W = SCR_WELCOME, P = SCR_PLAY, PA = SCR_PAUSE, E = SCR_END;

  initial begin
    resetN = 1'b0; resetN0 = 1'b0; startOfFrame = 1'b0;
    keyStart = 1'b1; keyStart0 = 1'b0; keyPause = 1'b0;
    life = 4'd3; life0 = 4'd3;
    rgbWelcome = 8'h11; rgbMain = 8'h22; rgbPause = 8'hFF; rgbEnd = 8'h44;

    // 1: key held through reset gives no edge; press starts game with blanking
    t("reset", W, 8'h00, 0, 0, 0);
    resetN = 1'b1;
    t("held1", W, 8'h11, 0, 0, 0);
    t("held2", W, 8'h11, 0, 0, 0);
    keyStart = 1'b0;
    t("release", W, 8'h11, 0, 0, 0);
    keyStart = 1'b1;
    t("start", P, 8'h11, 0, 0, 1);
    keyStart = 1'b0;
    t("ng_drop", P, 8'h00, 0, 0, 0);
    f("blank_f1", P, 8'h00, 0, 0, 0);
    f("blank_f2", P, 8'h00, 1, 0, 0);
    t("main_rgb", P, 8'h22, 1, 0, 0);

    // 2: pause with transparent and opaque overlay, then resume
    keyPause = 1'b1;
    t("pause", PA, 8'h22, 0, 1, 0);
    keyPause = 1'b0;
    t("pause_blank", PA, 8'h00, 0, 1, 0);
    f("pause_f1", PA, 8'h00, 0, 1, 0);
    f("pause_f2", PA, 8'h00, 0, 1, 0);
    t("transparent", PA, 8'h22, 0, 1, 0);
    rgbPause = 8'h1C;
    t("overlay", PA, 8'h1C, 0, 1, 0);
    rgbPause = 8'hFF;
    keyPause = 1'b1;
    t("unpause", P, 8'h22, 0, 0, 0);
    keyPause = 1'b0;
    t("unp_blank", P, 8'h00, 0, 0, 0);
    f("unp_f1", P, 8'h00, 0, 0, 0);
    f("unp_f2", P, 8'h00, 1, 0, 0);
    t("unp_main", P, 8'h22, 1, 0, 0);

    // 3: life==0 beats a simultaneous pause press
    life = 4'd0; keyPause = 1'b1;
    t("end_prio", E, 8'h22, 0, 0, 0);
    keyPause = 1'b0;
    t("end_blank", E, 8'h00, 0, 0, 0);

    // 4: timeout on the 4th frame strobe after END entry
    f("end_f1", E, 8'h00, 0, 0, 0);
    f("end_f2", E, 8'h00, 0, 0, 0);
    t("end_rgb", E, 8'h44, 0, 0, 0);
    f("end_f3", E, 8'h44, 0, 0, 0);
    f("timeout", W, 8'h44, 0, 0, 0);
    life = 4'd3;
    keyStart = 1'b1;
    t("wel_blank_key", W, 8'h00, 0, 0, 0);
    keyStart = 1'b0;
    f("wel_f1", W, 8'h00, 0, 0, 0);
    f("wel_f2", W, 8'h00, 0, 0, 0);
    t("wel_rgb", W, 8'h11, 0, 0, 0);

    // 5: start+pause together in PAUSE aborts; presses during blanking ignored
    keyStart = 1'b1;
    t("start2", P, 8'h11, 0, 0, 1);
    keyStart = 1'b0;
    t("s2_blank", P, 8'h00, 0, 0, 0);
    f("s2_f1", P, 8'h00, 0, 0, 0);
    f("s2_f2", P, 8'h00, 1, 0, 0);
    keyPause = 1'b1;
    t("pause2", PA, 8'h22, 0, 1, 0);
    keyPause = 1'b0;
    f("p2_f1", PA, 8'h00, 0, 1, 0);
    f("p2_f2", PA, 8'h00, 0, 1, 0);
    keyStart = 1'b1; keyPause = 1'b1;
    t("abort", W, 8'h22, 0, 0, 0);
    keyStart = 1'b0; keyPause = 1'b0;
    t("ab_blank", W, 8'h00, 0, 0, 0);
    keyStart = 1'b1;
    t("ab_key_s", W, 8'h00, 0, 0, 0);
    keyStart = 1'b0; keyPause = 1'b1;
    t("ab_key_p", W, 8'h00, 0, 0, 0);
    keyPause = 1'b0;
    f("ab_f1", W, 8'h00, 0, 0, 0);
    keyStart = 1'b1;
    t("ab_key_s2", W, 8'h00, 0, 0, 0);
    keyStart = 1'b0;
    f("ab_f2", W, 8'h00, 0, 0, 0);
    t("no_trans", W, 8'h11, 0, 0, 0);

    // 6: reset mid-game while blanking
    keyStart = 1'b1;
    t("start3", P, 8'h11, 0, 0, 1);
    keyStart = 1'b0;
    t("s3_blank", P, 8'h00, 0, 0, 0);
    resetN = 1'b0;
    t("rst_mid", W, 8'h00, 0, 0, 0);
    resetN = 1'b1;
    t("post_rst", W, 8'h11, 0, 0, 0);

    // 4b: END_TIMEOUT_FRAMES=0 holds END indefinitely
    tick();
    resetN0 = 1'b1;
    tick();
    keyStart0 = 1'b1;
    tick();
    ex("d0_start", 1'b1, P, 8'h11, 0, 0, 1);
    keyStart0 = 1'b0; life0 = 4'd0;
    startOfFrame = 1'b1;
    tick(); tick();
    startOfFrame = 1'b0;
    tick();
    ex("d0_end", 1'b1, E, 8'h22, 0, 0, 0);
    startOfFrame = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    startOfFrame = 1'b0;
    tick();
    ex("d0_hold", 1'b1, E, 8'h44, 0, 0, 0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
